// File: rtl/fmul_s2_skid.sv
// Elastic, fully registered hand-off stage between FP multiplier stages 1 and 3 (2-entry skid buffer).
// Optional macro TC_FMUL_S2_FLUSH_EN adds a synchronous flush_i that drops both entries.

`ifndef TC_EXPWIDTH
`define TC_EXPWIDTH 8
`endif
`ifndef TC_PRECISION
`define TC_PRECISION 24
`endif

module fmul_s2_skid #(
   parameter int unsigned EXPWIDTH  = `TC_EXPWIDTH,
   parameter int unsigned PRECISION = `TC_PRECISION
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
`ifdef TC_FMUL_S2_FLUSH_EN
   input  logic                   flush_i,
`endif
   input  logic                   in_valid_i,
   output logic                   in_ready_o,
   input  logic                   in_special_case_valid_i,
   input  logic                   in_special_case_nan_i,
   input  logic                   in_special_case_inf_i,
   input  logic                   in_special_case_inv_i,
   input  logic                   in_special_case_haszero_i,
   input  logic                   in_early_overflow_i,
   input  logic                   in_may_be_subnormal_i,
   input  logic [2:0]             in_rm_i,
   input  logic                   in_prod_sign_i,
   input  logic [EXPWIDTH:0]      in_shift_amt_i,
   input  logic [EXPWIDTH:0]      in_exp_shifted_i,
   input  logic [2*PRECISION-1:0] prod_i,
   output logic                   out_valid_o,
   input  logic                   out_ready_i,
   output logic                   out_special_case_valid_o,
   output logic                   out_special_case_nan_o,
   output logic                   out_special_case_inf_o,
   output logic                   out_special_case_inv_o,
   output logic                   out_special_case_haszero_o,
   output logic                   out_early_overflow_o,
   output logic                   out_may_be_subnormal_o,
   output logic [2:0]             out_rm_o,
   output logic                   out_prod_sign_o,
   output logic [EXPWIDTH:0]      out_shift_amt_o,
   output logic [EXPWIDTH:0]      out_exp_shifted_o,
   output logic [2*PRECISION-1:0] prod_o,
   output logic [1:0]             occ_o
);

   localparam int unsigned EW = EXPWIDTH + 1;
   localparam int unsigned PW = 2 * PRECISION;

   typedef struct packed {
      logic          sc_valid;
      logic          sc_nan;
      logic          sc_inf;
      logic          sc_inv;
      logic          sc_haszero;
      logic          early_ovf;
      logic          may_subn;
      logic [2:0]    rm;
      logic          sign;
      logic [EW-1:0] shift_amt;
      logic [EW-1:0] exp_shifted;
      logic [PW-1:0] prod;
   } bundle_t;

   // State encoding equals occupancy so occ_o comes straight from the state flops.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   state_t  r_state, w_state_nxt;
   logic    r_in_ready, r_out_valid;
   bundle_t r_main, r_skid;
   bundle_t w_in;
   logic    w_in_fire, w_out_fire, w_flush;
   logic    w_ld_main_in, w_ld_main_skid, w_ld_skid;

   assign w_in = '{
      sc_valid:    in_special_case_valid_i,
      sc_nan:      in_special_case_nan_i,
      sc_inf:      in_special_case_inf_i,
      sc_inv:      in_special_case_inv_i,
      sc_haszero:  in_special_case_haszero_i,
      early_ovf:   in_early_overflow_i,
      may_subn:    in_may_be_subnormal_i,
      rm:          in_rm_i,
      sign:        in_prod_sign_i,
      shift_amt:   in_shift_amt_i,
      exp_shifted: in_exp_shifted_i,
      prod:        prod_i
   };

`ifdef TC_FMUL_S2_FLUSH_EN
   assign w_flush = flush_i;
`else
   assign w_flush = 1'b0;
`endif

   assign w_in_fire  = in_valid_i & r_in_ready;
   assign w_out_fire = r_out_valid & out_ready_i;

   // Next state and payload load strobes; flush overrides everything.
   always_comb begin
      w_state_nxt    = r_state;
      w_ld_main_in   = 1'b0;
      w_ld_main_skid = 1'b0;
      w_ld_skid      = 1'b0;
      case (r_state)
         ST_EMPTY: begin
            if (w_in_fire) begin
               w_ld_main_in = 1'b1;
               w_state_nxt  = ST_ONE;
            end
         end
         ST_ONE: begin
            if (w_in_fire && w_out_fire) begin
               w_ld_main_in = 1'b1;
            end else if (w_in_fire) begin
               w_ld_skid   = 1'b1;
               w_state_nxt = ST_FULL;
            end else if (w_out_fire) begin
               w_state_nxt = ST_EMPTY;
            end
         end
         ST_FULL: begin
            if (w_out_fire) begin
               w_ld_main_skid = 1'b1;
               w_state_nxt    = ST_ONE;
            end
         end
         default: w_state_nxt = ST_EMPTY;
      endcase
      if (w_flush) begin
         w_state_nxt    = ST_EMPTY;
         w_ld_main_in   = 1'b0;
         w_ld_main_skid = 1'b0;
         w_ld_skid      = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state     <= ST_EMPTY;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_in_ready  <= (w_state_nxt != ST_FULL);
         r_out_valid <= (w_state_nxt != ST_EMPTY);
      end
   end

   // Payload registers load only on capture.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_main <= '0;
         r_skid <= '0;
      end else begin
         if (w_ld_main_in)        r_main <= w_in;
         else if (w_ld_main_skid) r_main <= r_skid;
         if (w_ld_skid)           r_skid <= w_in;
      end
   end

   assign in_ready_o                 = r_in_ready;
   assign out_valid_o                = r_out_valid;
   assign occ_o                      = 2'(r_state);
   assign out_special_case_valid_o   = r_main.sc_valid;
   assign out_special_case_nan_o     = r_main.sc_nan;
   assign out_special_case_inf_o     = r_main.sc_inf;
   assign out_special_case_inv_o     = r_main.sc_inv;
   assign out_special_case_haszero_o = r_main.sc_haszero;
   assign out_early_overflow_o       = r_main.early_ovf;
   assign out_may_be_subnormal_o     = r_main.may_subn;
   assign out_rm_o                   = r_main.rm;
   assign out_prod_sign_o            = r_main.sign;
   assign out_shift_amt_o            = r_main.shift_amt;
   assign out_exp_shifted_o          = r_main.exp_shifted;
   assign prod_o                     = r_main.prod;

endmodule

// File: tb/tb_fmul_s2_skid.sv
// Directed self-checking bench for fmul_s2_skid (EXPWIDTH=8, PRECISION=24).
// Flush cases compile in when TC_FMUL_S2_FLUSH_EN is defined.

module tb_fmul_s2_skid;

   localparam int unsigned BW = 77;

   logic        clk = 1'b0;
   logic        rst_ni;
   logic        in_valid_i, out_ready_i;
   logic        in_ready_o, out_valid_o;
   logic [1:0]  occ_o;
`ifdef TC_FMUL_S2_FLUSH_EN
   logic        flush_i;
`endif
   logic        in_sv, in_nan, in_inf, in_inv, in_hz, in_eo, in_sub, in_sign;
   logic [2:0]  in_rm;
   logic [8:0]  in_sh, in_ex;
   logic [47:0] in_prod;
   logic        o_sv, o_nan, o_inf, o_inv, o_hz, o_eo, o_sub, o_sign;
   logic [2:0]  o_rm;
   logic [8:0]  o_sh, o_ex;
   logic [47:0] o_prod;

   logic [BW-1:0] in_b;
   logic [BW-1:0] out_b;

   int n_checks = 0;
   int n_errors = 0;

   assign {in_sv, in_nan, in_inf, in_inv, in_hz, in_eo, in_sub, in_rm, in_sign, in_sh, in_ex, in_prod} = in_b;
   assign out_b = {o_sv, o_nan, o_inf, o_inv, o_hz, o_eo, o_sub, o_rm, o_sign, o_sh, o_ex, o_prod};

   always #5 clk = ~clk;

   fmul_s2_skid #(.EXPWIDTH(8), .PRECISION(24)) dut (
      .clk_i                      (clk),
      .rst_ni                     (rst_ni),
`ifdef TC_FMUL_S2_FLUSH_EN
      .flush_i                    (flush_i),
`endif
      .in_valid_i                 (in_valid_i),
      .in_ready_o                 (in_ready_o),
      .in_special_case_valid_i    (in_sv),
      .in_special_case_nan_i      (in_nan),
      .in_special_case_inf_i      (in_inf),
      .in_special_case_inv_i      (in_inv),
      .in_special_case_haszero_i  (in_hz),
      .in_early_overflow_i        (in_eo),
      .in_may_be_subnormal_i      (in_sub),
      .in_rm_i                    (in_rm),
      .in_prod_sign_i             (in_sign),
      .in_shift_amt_i             (in_sh),
      .in_exp_shifted_i           (in_ex),
      .prod_i                     (in_prod),
      .out_valid_o                (out_valid_o),
      .out_ready_i                (out_ready_i),
      .out_special_case_valid_o   (o_sv),
      .out_special_case_nan_o     (o_nan),
      .out_special_case_inf_o     (o_inf),
      .out_special_case_inv_o     (o_inv),
      .out_special_case_haszero_o (o_hz),
      .out_early_overflow_o       (o_eo),
      .out_may_be_subnormal_o     (o_sub),
      .out_rm_o                   (o_rm),
      .out_prod_sign_o            (o_sign),
      .out_shift_amt_o            (o_sh),
      .out_exp_shifted_o          (o_ex),
      .prod_o                     (o_prod),
      .occ_o                      (occ_o)
   );

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Distinct bundle per index; prod follows k*0x1_0001.
   function automatic logic [BW-1:0] mk(input int k);
      logic [47:0] p;
      p = 48'(k) * 48'h10001;
      return {7'(k * 5), 3'(k), 1'(k & 1), 9'(k * 3), 9'(~k), p};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   logic [BW-1:0] q[$];
   logic [BW-1:0] fld;
   logic          acc, pop;
   int            k;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst_ni      = 1'b0;
      in_valid_i  = 1'b0;
      out_ready_i = 1'b0;
      in_b        = '0;
`ifdef TC_FMUL_S2_FLUSH_EN
      flush_i     = 1'b0;
`endif
      #12;
      chk("rst_out_valid", out_valid_o, 0);
      chk("rst_occ", occ_o, 0);
      chk("rst_in_ready", in_ready_o, 1);
      chk("rst_bundle", out_b, 0);
      @(negedge clk);
      rst_ni = 1'b1;
      step();

      // Streaming: one bundle per cycle, each visible the cycle after capture.
      out_ready_i = 1'b1;
      in_valid_i  = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         in_b = mk(i);
         step();
         chk("stream_valid", out_valid_o, 1);
         chk("stream_data", out_b, mk(i));
         chk("stream_occ", occ_o, 1);
         chk("stream_ready", in_ready_o, 1);
      end
      in_valid_i = 1'b0;
      step();
      chk("stream_drain_occ", occ_o, 0);
      chk("stream_drain_valid", out_valid_o, 0);

      // Backpressure: A, B fill the buffer, C waits, then all drain in order.
      out_ready_i = 1'b0;
      in_valid_i  = 1'b1;
      in_b        = mk(100);
      step();
      chk("bp_a_occ", occ_o, 1);
      chk("bp_a_data", out_b, mk(100));
      in_b = mk(101);
      step();
      chk("bp_b_occ", occ_o, 2);
      chk("bp_b_ready", in_ready_o, 0);
      chk("bp_b_data", out_b, mk(100));
      in_b = mk(102);
      step();
      chk("bp_c_occ", occ_o, 2);
      chk("bp_c_stable", out_b, mk(100));
      step();
      chk("bp_c_stable2", out_b, mk(100));
      chk("bp_c_ready", in_ready_o, 0);
      out_ready_i = 1'b1;
      step();
      chk("bp_rel_b", out_b, mk(101));
      chk("bp_rel_occ", occ_o, 1);
      chk("bp_rel_ready", in_ready_o, 1);
      step();
      chk("bp_rel_c", out_b, mk(102));
      chk("bp_rel_c_occ", occ_o, 1);
      in_valid_i = 1'b0;
      step();
      chk("bp_empty", occ_o, 0);

      // Field integrity with edge values.
      fld        = {1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b100, 1'b1, 9'h1FF, 9'h000, 48'h8000_0000_0001};
      in_b       = fld;
      in_valid_i = 1'b1;
      step();
      in_valid_i = 1'b0;
      chk("fld_bundle", out_b, fld);
      chk("fld_rm", o_rm, 3'b100);
      chk("fld_shift", o_sh, 9'h1FF);
      chk("fld_exp", o_ex, 9'h000);
      chk("fld_flags", {o_nan, o_inv, o_sign, o_inf}, 4'b1110);
      step();
      chk("fld_empty", occ_o, 0);

      // Simultaneous fire with alternating out_ready, scoreboard-checked.
      k           = 200;
      in_b        = mk(k);
      in_valid_i  = 1'b1;
      out_ready_i = 1'b0;
      q.delete();
      for (int c = 0; c < 10; c++) begin
         acc = in_valid_i && (q.size() < 2);
         pop = (q.size() > 0) && out_ready_i;
         step();
         if (pop) void'(q.pop_front());
         if (acc) q.push_back(in_b);
         chk("sim_occ", occ_o, q.size());
         chk("sim_ready", in_ready_o, q.size() < 2);
         chk("sim_occ_range", (occ_o >= 1) && (occ_o <= 2), 1);
         if (q.size() > 0) chk("sim_data", out_b, q[0]);
         if (acc) begin
            k++;
            in_b = mk(k);
         end
         out_ready_i = (c % 2 == 0);
      end
      in_valid_i  = 1'b0;
      out_ready_i = 1'b1;
      for (int c = 0; c < 4 && q.size() > 0; c++) begin
         step();
         void'(q.pop_front());
         chk("sim_drain_occ", occ_o, q.size());
         if (q.size() > 0) chk("sim_drain_data", out_b, q[0]);
      end
      chk("sim_drained", occ_o, 0);

`ifdef TC_FMUL_S2_FLUSH_EN
      // Flush while FULL with a same-cycle input and ready downstream.
      out_ready_i = 1'b0;
      in_valid_i  = 1'b1;
      in_b        = mk(300);
      step();
      in_b = mk(301);
      step();
      chk("fl_full", occ_o, 2);
      in_b        = mk(302);
      flush_i     = 1'b1;
      out_ready_i = 1'b1;
      step();
      flush_i    = 1'b0;
      in_valid_i = 1'b0;
      chk("fl_occ", occ_o, 0);
      chk("fl_valid", out_valid_o, 0);
      chk("fl_ready", in_ready_o, 1);
      step();
      chk("fl_still_empty", out_valid_o, 0);
      in_valid_i = 1'b1;
      in_b       = mk(303);
      step();
      in_valid_i = 1'b0;
      chk("fl_next_data", out_b, mk(303));
      step();
`endif

      // Reset asserted mid-FULL clears immediately.
      out_ready_i = 1'b0;
      in_valid_i  = 1'b1;
      in_b        = mk(400);
      step();
      in_b = mk(401);
      step();
      in_valid_i = 1'b0;
      chk("rf_full", occ_o, 2);
      rst_ni = 1'b0;
      #1;
      chk("rf_valid", out_valid_o, 0);
      chk("rf_occ", occ_o, 0);
      chk("rf_ready", in_ready_o, 1);
      chk("rf_prod", o_prod, 0);
      @(negedge clk);
      rst_ni = 1'b1;
      step();
      chk("rf_after", out_valid_o, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
